// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants, state type and helpers for the 4-to-2 handshake encoder
// Purpose : line count, code width, FSM state enum, round-robin pointer reset value
//           and a code-to-one-hot helper used by the encoder datapath.
// Ports   : none (package).
package enc_pkg;

   localparam int LINES  = 4;
   localparam int CODE_W = 2;

   // Pointer resets to the last line so the first round-robin search starts at line 0.
   localparam logic [CODE_W-1:0] PTR_RST = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   function automatic logic [LINES-1:0] line_onehot(input logic [CODE_W-1:0] code);
      logic [LINES-1:0] v;
      v       = '0;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/encoder_4x2_hs_if.sv
// rtl/encoder_4x2_hs_if.sv - request/code handshake bundle between event sources and consumer
// Purpose : groups the request lines, encoded output handshake and status signals.
// Signals : req[3:0]  request lines, bit k requests line k
//           a, b      encoded line {a,b}
//           out_valid {a,b} holds a pending line
//           out_ready consumer accepts the code
//           pend[3:0] pending register (status)
//           ovf       an event merged into an already-pending line
// Modports: master = encoder side, slave = source/consumer side.
interface encoder_4x2_hs_if;

   logic [enc_pkg::LINES-1:0] req;
   logic                      a;
   logic                      b;
   logic                      out_valid;
   logic                      out_ready;
   logic [enc_pkg::LINES-1:0] pend;
   logic                      ovf;

   modport master (
      input  req,
      input  out_ready,
      output a,
      output b,
      output out_valid,
      output pend,
      output ovf
   );

   modport slave (
      output req,
      output out_ready,
      input  a,
      input  b,
      input  out_valid,
      input  pend,
      input  ovf
   );

endinterface

// File: rtl/priority_pick_4.sv
// rtl/priority_pick_4.sv - rotating first-set search over four lines
// Purpose : returns the first set bit of vec, searching upward from index start
//           and wrapping; start = 0 gives plain lowest-index priority.
// Ports   : vec[3:0]  candidate lines
//           start     first index examined
//           code      selected line index
//           found     vec had at least one bit set
module priority_pick_4
   import enc_pkg::*;
(
   input  logic [LINES-1:0]  vec,
   input  logic [CODE_W-1:0] start,
   output logic [CODE_W-1:0] code,
   output logic              found
);

   logic [CODE_W-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest set line is the last writer.
   always_comb begin
      code  = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = LINES - 1; i >= 0; i--) begin
         idx = start + CODE_W'(i);
         if (vec[idx]) begin
            code  = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_4x2_hs.sv
// rtl/encoder_4x2_hs.sv - registered 4-to-2 encoder with pending register and valid/ready output
// Purpose : captures request events into a pending register and serves them one per
//           handshake as code {a,b}; line k = 2a+b.
// Ports   : clk       rising-edge clock
//           rst_n     asynchronous active-low reset
//           bus       encoder_4x2_hs_if.master (req, out_ready in; a, b, out_valid, pend, ovf out)
// Params  : OVF_STICKY 0 = ovf is a one-cycle pulse, 1 = ovf holds until reset
// Macro   : ENC_RR_EN  defined = round-robin selection, undefined = lowest index first
module encoder_4x2_hs
   import enc_pkg::*;
#(
   parameter bit OVF_STICKY = 1'b0
) (
   input logic              clk,
   input logic              rst_n,
   encoder_4x2_hs_if.master bus
);

   state_t            state_q;
   logic [LINES-1:0]  pend_q;
   logic [LINES-1:0]  pend_d;
   logic [CODE_W-1:0] code_q;
   logic              valid_q;
   logic              ovf_q;

   logic              hs;
   logic [LINES-1:0]  clr;
   logic [LINES-1:0]  hit;
   logic [LINES-1:0]  pick_vec;
   logic [CODE_W-1:0] start;
   logic [CODE_W-1:0] pick_code;
   logic              pick_found;

   assign hs     = valid_q & bus.out_ready;
   assign clr    = hs ? line_onehot(code_q) : '0;
   // A request on the line being cleared re-arms it as a fresh event.
   assign pend_d = (pend_q & ~clr) | bus.req;
   assign hit    = bus.req & pend_q & ~clr;

   // IDLE presents from the registered pending set (two-cycle request latency);
   // HOLD reloads back-to-back from the post-handshake set.
   assign pick_vec = (state_q == HOLD) ? pend_d : pend_q;

`ifdef ENC_RR_EN
   logic [CODE_W-1:0] ptr_q;

   // On a handshake the served line becomes the pointer on this same edge.
   assign start = (hs ? code_q : ptr_q) + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= PTR_RST;
      end else if (hs) begin
         ptr_q <= code_q;
      end
   end
`else
   assign start = '0;
`endif

   priority_pick_4 u_pick (
      .vec   (pick_vec),
      .start (start),
      .code  (pick_code),
      .found (pick_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= OVF_STICKY ? (ovf_q | (|hit)) : (|hit);
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  code_q  <= pick_code;
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (hs) begin
                  if (pick_found) begin
                     code_q <= pick_code;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.a         = code_q[1];
   assign bus.b         = code_q[0];
   assign bus.out_valid = valid_q;
   assign bus.pend      = pend_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_encoder_4x2_hs.sv
// tb/tb_encoder_4x2_hs.sv - self-checking bench for encoder_4x2_hs
module tb_encoder_4x2_hs;

   localparam bit STICKY = 1'b0;

   logic clk;
   logic rst_n;

   encoder_4x2_hs_if bus ();

   encoder_4x2_hs #(
      .OVF_STICKY (STICKY)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 2-to-4 line decoder fed by the encoded output (loopback)
   logic [3:0] dec_r;
   assign dec_r = 4'b0001 << {bus.a, bus.b};

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit mp[4];
   bit mv;
   int ml;
   int mptr;
   bit movf;

   int events_in;
   int hs_count;
   int dut_served[$];
   bit ovf_seen;
   bit prev_valid;
   int prev_code;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input bit v[4], input int first);
      for (int i = 0; i < 4; i++) begin
         if (v[(first + i) % 4]) return (first + i) % 4;
      end
      return -1;
   endfunction

   function automatic int search_start();
`ifdef ENC_RR_EN
      return (mptr + 1) % 4;
`else
      return 0;
`endif
   endfunction

   function automatic int pack_pend();
      int s = 0;
      for (int k = 0; k < 4; k++) if (mp[k]) s += (1 << k);
      return s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) mp[k] = 1'b0;
      mv   = 1'b0;
      ml   = 0;
      mptr = 3;
      movf = 1'b0;
   endtask

   // One clock edge of the encoder's rules, given the inputs sampled at that edge.
   task automatic model_step(input logic [3:0] r, input logic rdy);
      bit hs;
      bit coll;
      bit nxt[4];
      int sel;
      hs   = mv && rdy;
      coll = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bit keep;
         keep = mp[k] && !(hs && ml == k);
         if (r[k]) begin
            if (keep) coll = 1'b1;
            else events_in++;
         end
         nxt[k] = keep || r[k];
      end
      if (hs) mptr = ml;
      if (!mv) begin
         sel = pick(mp, search_start());
         if (sel >= 0) begin
            ml = sel;
            mv = 1'b1;
         end
      end else if (hs) begin
         sel = pick(nxt, search_start());
         if (sel >= 0) ml = sel;
         else mv = 1'b0;
      end
      movf = STICKY ? (movf | coll) : coll;
      for (int k = 0; k < 4; k++) mp[k] = nxt[k];
   endtask

   // Compare process: inputs are changed 1 time unit after each falling edge,
   // so at the falling edge they still hold the values the last rising edge sampled.
   initial begin
      model_reset();
      prev_valid = 1'b0;
      prev_code  = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_reset();
         end else begin
            model_step(bus.req, bus.out_ready);
            if (prev_valid && bus.out_ready) begin
               dut_served.push_back(prev_code);
               hs_count++;
            end
         end
         chk("valid", int'(bus.out_valid), int'(mv));
         chk("pend", int'(bus.pend), pack_pend());
         chk("ovf", int'(bus.ovf), int'(movf));
         if (mv) begin
            chk("code", int'({bus.a, bus.b}), ml);
            chk("loopback", int'(dec_r), 1 << ml);
         end
         if (bus.ovf) ovf_seen = 1'b1;
         prev_valid = bus.out_valid && rst_n;
         prev_code  = int'({bus.a, bus.b});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      bus.req       = 4'b0000;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      step(2);
      rst_n = 1'b1;
      dut_served.delete();
      ovf_seen  = 1'b0;
      events_in = 0;
      hs_count  = 0;
   endtask

   task automatic chk_served(input string name, input int exp[$]);
      chk({name, "_count"}, dut_served.size(), exp.size());
      for (int i = 0; i < exp.size() && i < dut_served.size(); i++)
         chk({name, "_line"}, dut_served[i], exp[i]);
   endtask

   initial begin
      int exp_q[$];
      rst_n         = 1'b0;
      bus.req       = 4'b0000;
      bus.out_ready = 1'b0;
      events_in     = 0;
      hs_count      = 0;
      ovf_seen      = 1'b0;

      // reset state
      do_reset();
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_pend", int'(bus.pend), 0);
      chk("rst_ab", int'({bus.a, bus.b}), 0);
      chk("rst_ovf", int'(bus.ovf), 0);

      // single request held by a stalled consumer
      bus.req = 4'b0010;
      step(1);
      bus.req = 4'b0000;
      chk("t1_lat_valid", int'(bus.out_valid), 0);
      chk("t1_lat_pend", int'(bus.pend), 2);
      step(1);
      chk("t1_valid", int'(bus.out_valid), 1);
      chk("t1_code", int'({bus.a, bus.b}), 1);
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("t1_hold_valid", int'(bus.out_valid), 1);
         chk("t1_hold_code", int'({bus.a, bus.b}), 1);
      end
      bus.out_ready = 1'b1;
      step(1);
      bus.out_ready = 1'b0;
      chk("t1_done_valid", int'(bus.out_valid), 0);
      chk("t1_done_pend", int'(bus.pend), 0);
      exp_q = '{1};
      chk_served("t1_served", exp_q);

      // burst on all lines, consumer always ready
      do_reset();
      bus.req       = 4'b1111;
      bus.out_ready = 1'b1;
      step(1);
      bus.req = 4'b0000;
      step(8);
      exp_q = '{0, 1, 2, 3};
      chk_served("t2_served", exp_q);
      chk("t2_ovf_seen", int'(ovf_seen), 0);

      // held request on an unserved line merges and overflows
      do_reset();
      bus.req = 4'b0100;
      step(3);
      bus.req = 4'b0000;
      step(2);
      chk("t3_ovf_seen", int'(ovf_seen), 1);
      bus.out_ready = 1'b1;
      step(4);
      exp_q = '{2};
      chk_served("t3_served", exp_q);

      // request on the line being cleared re-arms it
      do_reset();
      bus.req = 4'b0010;
      step(1);
      bus.req = 4'b0000;
      step(1);
      bus.req       = 4'b0010;
      bus.out_ready = 1'b1;
      step(1);
      bus.req = 4'b0000;
      chk("t4_pend", int'(bus.pend), 2);
      chk("t4_valid", int'(bus.out_valid), 1);
      chk("t4_code", int'({bus.a, bus.b}), 1);
      step(1);
      chk("t4_idle", int'(bus.out_valid), 0);
      exp_q = '{1, 1};
      chk_served("t4_served", exp_q);
      chk("t4_ovf_seen", int'(ovf_seen), 0);

      // all lines held continuously
      do_reset();
      bus.req       = 4'b1111;
      bus.out_ready = 1'b1;
      step(8);
      bus.req       = 4'b0000;
      bus.out_ready = 1'b0;
`ifdef ENC_RR_EN
      exp_q = '{0, 1, 2, 3, 0, 1};
`else
      exp_q = '{0, 0, 0, 0, 0, 0};
`endif
      chk_served("t5_served", exp_q);

      // reset in the middle of HOLD
      do_reset();
      bus.req = 4'b1010;
      step(1);
      bus.req = 4'b0000;
      step(1);
      chk("t6_pend", int'(bus.pend), 10);
      chk("t6_valid", int'(bus.out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", int'(bus.out_valid), 0);
      chk("t6_rst_ab", int'({bus.a, bus.b}), 0);
      chk("t6_rst_pend", int'(bus.pend), 0);
      chk("t6_rst_ovf", int'(bus.ovf), 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      dut_served.delete();
      bus.out_ready = 1'b1;
      step(5);
      chk("t6_after_count", dut_served.size(), 0);
      chk("t6_after_valid", int'(bus.out_valid), 0);

      // random traffic, then drain; every non-merged event must be served once
      do_reset();
      for (int i = 0; i < 600; i++) begin
         bus.req       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         bus.out_ready = ($urandom_range(0, 2) != 0);
         step(1);
      end
      bus.req       = 4'b0000;
      bus.out_ready = 1'b1;
      step(12);
      chk("rand_conservation", hs_count, events_in);
      chk("rand_drained", int'(bus.pend), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/encoder_4x2_hs.md
# encoder_4x2_hs

Registered 4-to-2 encoder with valid/ready output handshake; the inverse of the 2x4 line decoder in the Vedic multiplier datapath. It captures events on four request lines into a pending register, then serves them one at a time as a 2-bit code `{a,b}`. Driving that code into `decoder_2x4` reproduces the served line. It sits between event sources and any consumer that accepts one encoded line per handshake.

## Interface
- `OVF_STICKY`, default 0: 0 = `ovf` is a one-cycle pulse; 1 = `ovf` stays high until reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in [0:3]: request lines, level-sampled every cycle; bit k requests line k.
- `a` out 1: code MSB; line k = 2a+b.
- `b` out 1: code LSB.
- `out_valid` out 1: `{a,b}` holds a pending line.
- `out_ready` in 1: consumer accepts the code when `out_valid` is also high.
- `pend` out [0:3]: pending register, for debug/status.
- `ovf` out 1: a request merged into an already-pending line, so one event was lost.

## Operation
- Reset (async, `rst_n`=0): `pend`=0, `a`=0, `b`=0, `out_valid`=0, `ovf`=0, state IDLE, round-robin pointer=3.
- Pending update each edge: `pend <= (pend & ~clr) | req`.
  - `clr` is the one-hot of the served line when `out_valid & out_ready`, else 0.
  - `req` on the line being cleared in the same cycle wins: the bit stays set as a new event.
- Overflow: `ovf` is asserted for any bit k with `req[k] & pend[k] & ~clr[k]`.
- States:
  - IDLE: `out_valid`=0. If registered `pend` != 0, load `{a,b}` with the selected line, set `out_valid`, go to HOLD.
  - HOLD: `a`, `b`, `out_valid` stay stable while `out_ready`=0. On handshake, compute next = `(pend & ~clr) | req`.
    - If next != 0, load its selected line on the same edge (back-to-back) and stay in HOLD.
    - Otherwise clear `out_valid` and go to IDLE.
- Selection, default: fixed priority, lowest index first (line 0 = `{0,0}` wins).
- `out_ready` is ignored in IDLE.
- A line is never dropped. Each distinct (non-merged) event is served exactly once.

## Timing
- Request to valid: `req[k]` sampled at edge t sets `pend[k]` at t; `out_valid` rises after edge t+1. Latency is 2 cycles from the sampled edge.
- Throughput: 1 code per cycle while `out_ready`=1 and `pend` stays non-empty.
- The cleared bit drops from `pend` on the handshake edge.
- Reset asserted mid-HOLD discards the pending and presented codes immediately, with no handshake.
- After reset release, the first cycle behaves as IDLE with `pend`=0.
- The `ovf` pulse (`OVF_STICKY`=0) is registered and appears one cycle after the colliding `req` edge.

## Configuration
- `ENC_RR_EN` defined: round-robin selection.
  - The search starts at line (ptr+1) mod 4.
  - `ptr` updates to the served line on each handshake.
  - Reset `ptr`=3, so line 0 is served first.
  - Lines 0..3 all pending continuously are served in the order 0,1,2,3,0,…
- `ENC_RR_EN` undefined: fixed lowest-index priority, and no pointer register exists.

## Structure
- Package `enc_pkg`:
  - `LINES`=4 and `CODE_W`=2.
  - State enum {IDLE, HOLD}.
  - Pointer reset constant 2'd3.
- Sub-module `priority_pick_4`: combinational. Inputs `vec[0:3]` and start index; outputs 2-bit code and `found`. It is instantiated once on the next-pending vector.

## Test plan
- Reset, then pulse `req`=4'b0010 for one cycle with `out_ready`=0 → `out_valid`=1 two edges later, `{a,b}`=01, held for 5 cycles; raise `out_ready` → one handshake, then `out_valid`=0 and `pend`=0.
- `req`=4'b1111 for one cycle, `out_ready`=1 → codes 00,01,10,11 on consecutive cycles; `ovf`=0.
- Hold `req[2]`=1 for 3 cycles while line 2 is unserved → `ovf` pulses; line 2 is served once (merged).
- Handshake on line 1 while `req[1]`=1 in the same cycle → `pend[1]` stays 1 and line 1 is served again next.
- `ENC_RR_EN`, `req`=4'b1111 held, `out_ready`=1 → sequence 0,1,2,3,0,1; without the macro → 0,0,0,…
- Assert `rst_n`=0 mid-HOLD with `pend`=4'b1010 → all outputs 0 immediately; no code is emitted after release.
- Loopback: feed `{a,b}` into `decoder_2x4` → its `R` equals the one-hot of the served line for every handshake.
